// File: rtl/qsys_gpo_sequencer.sv
// Avalon-MM pattern sequencer for a 32-bit GPO bus.
// Steps a loaded table onto coe_GPO with a fixed per-step hold time.
module qsys_gpo_sequencer #(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] IDLE_RESET = 32'h5A5A5A5A
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [2:0]  avs_Seq_address,
    input  logic        avs_Seq_read,
    output logic [31:0] avs_Seq_readdata,
    input  logic        avs_Seq_write,
    input  logic [31:0] avs_Seq_writedata,
    output logic        avs_Seq_waitrequest,
    output logic [31:0] coe_GPO,
    output logic        coe_Busy,
    output logic        ins_Done_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t state, stateNext;

    logic [31:0]   tbl [DEPTH];
    logic [8:0]    lenReg;
    logic [31:0]   holdReg;
    logic [31:0]   idleReg;
    logic [AW-1:0] tAddr;
    logic          loopEn;
    logic          irqEn;
    logic          done;
    logic [AW-1:0] index;
    logic [AW-1:0] lastS;
    logic [31:0]   reloadS;
    logic [31:0]   cnt;

    logic [7:0]    wrSel;
    logic          startReq;
    logic          stopReq;
    logic [8:0]    effLen;
    logic [8:0]    effLenM1;
    logic [31:0]   holdReload;
    logic [31:0]   idleNext;
    logic [AW-1:0] nextIdx;
    logic          doLoad;
    logic          doStep;
    logic          doWrap;
    logic          doDec;
    logic          doFinish;
    logic          unusedRead;

    assign unusedRead = avs_Seq_read;

    assign wrSel    = avs_Seq_write ? (8'd1 << avs_Seq_address) : 8'd0;
    assign startReq = wrSel[0] & avs_Seq_writedata[0];
    assign stopReq  = wrSel[0] & avs_Seq_writedata[1];

    // Shadow values: length clamped to the table, hold of 0 acts as 1
    assign effLen     = (lenReg > DEPTH9) ? DEPTH9 : lenReg;
    assign effLenM1   = effLen - 9'd1;
    assign holdReload = (holdReg == 32'd0) ? 32'd0 : holdReg - 32'd1;
    assign idleNext   = wrSel[4] ? avs_Seq_writedata : idleReg;
    assign nextIdx    = index + 1'b1;

    assign avs_Seq_waitrequest = rsi_MRST_reset;
    assign coe_Busy            = (state == ST_RUN);
    assign ins_Done_irq        = done & irqEn;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        doLoad    = 1'b0;
        doStep    = 1'b0;
        doWrap    = 1'b0;
        doDec     = 1'b0;
        doFinish  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (startReq && !stopReq && effLen != 9'd0) begin
                    stateNext = ST_RUN;
                    doLoad    = 1'b1;
                end
            end
            ST_RUN: begin
                if (stopReq) begin
                    stateNext = ST_IDLE;
                end else if (startReq) begin
                    if (effLen != 9'd0) begin
                        doLoad = 1'b1;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end else if (cnt != 32'd0) begin
                    doDec = 1'b1;
                end else if (index != lastS) begin
                    doStep = 1'b1;
                end else if (loopEn) begin
                    doWrap = 1'b1;
                end else begin
                    stateNext = ST_IDLE;
                    doFinish  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            lenReg  <= '0;
            holdReg <= '0;
            idleReg <= IDLE_RESET;
            tAddr   <= '0;
            loopEn  <= 1'b0;
            irqEn   <= 1'b0;
            done    <= 1'b0;
            index   <= '0;
            lastS   <= '0;
            reloadS <= '0;
            cnt     <= '0;
            coe_GPO <= IDLE_RESET;
        end else begin
            if (wrSel[0]) begin
                loopEn <= avs_Seq_writedata[2];
                irqEn  <= avs_Seq_writedata[3];
            end
            if (wrSel[2]) lenReg <= avs_Seq_writedata[8:0];
            if (wrSel[3]) holdReg <= avs_Seq_writedata;
            idleReg <= idleNext;
            if (wrSel[5]) begin
                tAddr <= avs_Seq_writedata[AW-1:0];
            end else if (wrSel[6]) begin
                tAddr <= tAddr + 1'b1;
            end
            // A completion in the same cycle as a W1C keeps DONE set
            if (doFinish) begin
                done <= 1'b1;
            end else if (wrSel[1] && avs_Seq_writedata[1]) begin
                done <= 1'b0;
            end
            if (doLoad) begin
                lastS   <= effLenM1[AW-1:0];
                reloadS <= holdReload;
                cnt     <= holdReload;
                index   <= '0;
                coe_GPO <= tbl[0];
            end else if (doStep) begin
                index   <= nextIdx;
                cnt     <= reloadS;
                coe_GPO <= tbl[nextIdx];
            end else if (doWrap) begin
                index   <= '0;
                cnt     <= reloadS;
                coe_GPO <= tbl[0];
            end else if (doDec) begin
                cnt <= cnt - 32'd1;
            end else if (stateNext == ST_IDLE) begin
                coe_GPO <= idleNext;
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (wrSel[6]) tbl[tAddr] <= avs_Seq_writedata;
    end

    always_comb begin
        avs_Seq_readdata = '0;
        case (avs_Seq_address)
            3'd0: avs_Seq_readdata = {28'd0, irqEn, loopEn, 2'b00};
            3'd1: avs_Seq_readdata = {16'd0, 8'(index), 6'd0, done, coe_Busy};
            3'd2: avs_Seq_readdata = {23'd0, lenReg};
            3'd3: avs_Seq_readdata = holdReg;
            3'd4: avs_Seq_readdata = idleReg;
            3'd5: avs_Seq_readdata = 32'(tAddr);
            3'd6: avs_Seq_readdata = tbl[tAddr];
            default: avs_Seq_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_qsys_gpo_sequencer.sv
// Directed bench for qsys_gpo_sequencer: register table plus
// hand-timed run, loop, stop, clamp and async-reset sequences.
module tb_qsys_gpo_sequencer;

    localparam logic [31:0] IR = 32'h5A5A5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  addr = '0;
    logic        rdEn = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        waitReq;
    logic [31:0] gpo;
    logic        busy;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    vec_t vecs [12];
    logic [31:0] seq3 [6];

    always #5 clk = ~clk;

    qsys_gpo_sequencer #(
        .DEPTH(16),
        .IDLE_RESET(32'h5A5A5A5A)
    ) dut (
        .csi_MCLK_clk(clk),
        .rsi_MRST_reset(rst),
        .avs_Seq_address(addr),
        .avs_Seq_read(rdEn),
        .avs_Seq_readdata(rdata),
        .avs_Seq_write(we),
        .avs_Seq_writedata(wdata),
        .avs_Seq_waitrequest(waitReq),
        .coe_GPO(gpo),
        .coe_Busy(busy),
        .ins_Done_irq(irq)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rdChk(input logic [2:0] a, input logic [31:0] e,
                         input string nm);
        addr = a;
        rdEn = 1'b1;
        #1;
        chk(nm, rdata, e);
        rdEn = 1'b0;
    endtask

    task automatic doneChk(input logic e, input string nm);
        addr = 3'd1;
        #1;
        chk(nm, 32'(rdata[1]), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFF_FFFC, 32'h0000_000C};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_01FF};
        vecs[2]  = '{3'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3]  = '{3'd4, 32'h1234_5678, 32'h1234_5678};
        vecs[4]  = '{3'd5, 32'hFFFF_FFF3, 32'h0000_0003};
        vecs[5]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{3'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{3'd2, 32'h0000_FE00, 32'h0000_0000};
        vecs[9]  = '{3'd3, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{3'd4, IR,            IR};
        vecs[11] = '{3'd5, 32'h0000_0000, 32'h0000_0000};
        seq3 = '{32'h11, 32'h11, 32'h22, 32'h22, 32'h33, 32'h33};

        // reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_wait", 32'(waitReq), 32'd1);
        chk("rst_gpo", gpo, IR);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("wait_low", 32'(waitReq), 32'd0);
        rdChk(3'd4, IR, "rst_idle");
        rdChk(3'd1, 32'd0, "rst_status");
        chk("rst_irq", 32'(irq), 32'd0);

        // register readback table
        for (int i = 0; i < 12; i++) begin
            wr(vecs[i].a, vecs[i].d);
            rdChk(vecs[i].a, vecs[i].e, "reg");
            if (vecs[i].a == 3'd4) begin
                tick();
                chk("gpo_idle", gpo, vecs[i].e);
            end
        end

        // table load, TDATA read without increment
        wr(3'd5, 0);
        wr(3'd6, 32'h11);
        wr(3'd6, 32'h22);
        wr(3'd6, 32'h33);
        rdChk(3'd5, 32'd3, "taddr_inc");
        wr(3'd5, 0);
        rdChk(3'd6, 32'h11, "tdata_rd");
        rdChk(3'd5, 32'd0, "taddr_noinc");

        // single run, LEN=3 HOLD=2, IRQ_EN
        wr(3'd2, 3);
        wr(3'd3, 2);
        wr(3'd0, 8);
        wr(3'd0, 9);
        for (int i = 0; i < 6; i++) begin
            chk("run3_gpo", gpo, seq3[i]);
            chk("run3_busy", 32'(busy), 32'd1);
            chk("run3_irq", 32'(irq), 32'd0);
            if (i == 2) rdChk(3'd1, 32'h0000_0101, "run3_status");
            tick();
        end
        chk("end3_gpo", gpo, IR);
        chk("end3_busy", 32'(busy), 32'd0);
        chk("end3_irq", 32'(irq), 32'd1);
        doneChk(1'b1, "end3_done");
        wr(3'd1, 2);
        chk("w1c_irq", 32'(irq), 32'd0);
        doneChk(1'b0, "w1c_done");

        // loop with HOLD=0, then clear LOOP mid-run
        wr(3'd5, 0);
        wr(3'd6, 32'hAA);
        wr(3'd6, 32'hBB);
        wr(3'd2, 2);
        wr(3'd3, 0);
        wr(3'd0, 5);
        for (int i = 0; i < 6; i++) begin
            chk("loop_gpo", gpo, (i % 2 == 1) ? 32'hBB : 32'hAA);
            tick();
        end
        wr(3'd0, 0);
        chk("unloop_gpo", gpo, 32'hBB);
        chk("unloop_busy", 32'(busy), 32'd1);
        tick();
        chk("unloop_end", gpo, IR);
        chk("unloop_idle", 32'(busy), 32'd0);
        doneChk(1'b1, "unloop_done");
        wr(3'd1, 2);

        // STOP mid-run at index 1
        wr(3'd3, 3);
        wr(3'd0, 1);
        tick();
        tick();
        tick();
        chk("stop_pre", gpo, 32'hBB);
        rdChk(3'd1, 32'h0000_0101, "stop_idx");
        wr(3'd0, 2);
        chk("stop_gpo", gpo, IR);
        chk("stop_busy", 32'(busy), 32'd0);
        doneChk(1'b0, "stop_done");

        // START and STOP together
        wr(3'd0, 3);
        chk("ss_busy", 32'(busy), 32'd0);
        chk("ss_gpo", gpo, IR);
        tick();
        chk("ss_busy2", 32'(busy), 32'd0);

        // LEN=0 start ignored
        wr(3'd2, 0);
        wr(3'd0, 1);
        chk("len0_busy", 32'(busy), 32'd0);
        doneChk(1'b0, "len0_done");

        // 17 TDATA writes wrap, then LEN=40 clamps to 16 steps
        wr(3'd5, 0);
        for (int i = 0; i < 17; i++) wr(3'd6, 32'h1000 + 32'(i));
        rdChk(3'd5, 32'd1, "wrap_taddr");
        rdChk(3'd6, 32'h1001, "wrap_t1");
        wr(3'd5, 0);
        rdChk(3'd6, 32'h1010, "wrap_t0");
        wr(3'd2, 40);
        wr(3'd3, 0);
        wr(3'd0, 1);
        for (int k = 0; k < 16; k++) begin
            chk("clamp_gpo", gpo, (k == 0) ? 32'h1010 : 32'h1000 + 32'(k));
            tick();
        end
        chk("clamp_end", gpo, IR);
        chk("clamp_busy", 32'(busy), 32'd0);
        doneChk(1'b1, "clamp_done");
        wr(3'd1, 2);

        // async reset mid-run
        wr(3'd4, 32'h0F0F_0F0F);
        wr(3'd2, 3);
        wr(3'd3, 5);
        wr(3'd0, 1);
        tick();
        chk("ar_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_gpo", gpo, IR);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_wait", 32'(waitReq), 32'd1);
        #1 rst = 1'b0;
        tick();
        chk("ar_gpo2", gpo, IR);
        rdChk(3'd2, 32'd0, "ar_len");
        rdChk(3'd3, 32'd0, "ar_hold");
        rdChk(3'd4, IR, "ar_idle");
        rdChk(3'd1, 32'd0, "ar_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
